// File: rtl/vec_stride_lsu.sv
// Strided vector load/store unit: walks vl elements at base + i*stride, one
// aligned 32-bit memory beat per element, with lane shifting and byte strobes.
module vec_stride_lsu #(
  parameter int unsigned MAX_VL = 32,
  parameter int unsigned VLW    = $clog2(MAX_VL + 1)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_store,
  input  logic [31:0]    cmd_base,
  input  logic [31:0]    cmd_stride,
  input  logic [VLW-1:0] cmd_vl,
  input  logic [1:0]     cmd_sew,
  output logic           ld_valid,
  input  logic           ld_ready,
  output logic [31:0]    ld_data,
  output logic [VLW-1:0] ld_idx,
  input  logic           st_valid,
  output logic           st_ready,
  input  logic [31:0]    st_data,
  output logic           mem_valid,
  input  logic           mem_ready,
  output logic [31:0]    mem_addr,
  output logic [31:0]    mem_wdata,
  output logic [3:0]     mem_wstrb,
  input  logic [31:0]    mem_rdata,
  output logic           done,
  output logic           err
);

  typedef enum logic [2:0] {S_IDLE, S_STW, S_MEM, S_LDO, S_FIN} state_t;

  state_t         r_state, w_nxt_state;
  logic           w_nxt_err, r_err;
  logic           r_store;
  logic [1:0]     r_sew;
  logic [31:0]    r_addr, r_stride;
  logic [VLW-1:0] r_vl, r_i;
  logic           r_mem_valid;
  logic [31:0]    r_mem_addr, r_wdata, r_ld_data;
  logic [3:0]     r_wstrb;

  logic [VLW-1:0] w_vl_clamp;
  logic [31:0]    w_nxt_addr;
  logic [1:0]     w_off;
  logic           w_last;

  function automatic logic f_misal(input logic [1:0] a, input logic [1:0] sew);
    case (sew)
      2'd1:    return a[0];
      2'd2:    return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] f_mask(input logic [1:0] sew);
    case (sew)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [3:0] f_smask(input logic [1:0] sew);
    case (sew)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  assign w_vl_clamp = (cmd_vl > VLW'(MAX_VL)) ? VLW'(MAX_VL) : cmd_vl;
  assign w_nxt_addr = r_addr + r_stride;
  assign w_off      = r_addr[1:0];
  assign w_last     = (r_i == r_vl - VLW'(1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_nxt_state;
  end

  // Alignment of the next element is checked on the advancing edge, so a
  // misaligned element never raises mem_valid or st_ready.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_err   = r_err;
    unique case (r_state)
      S_IDLE: if (cmd_valid) begin
        if (w_vl_clamp == '0) begin
          w_nxt_state = S_FIN;
          w_nxt_err   = 1'b0;
        end else if (cmd_sew == 2'b11 || f_misal(cmd_base[1:0], cmd_sew)) begin
          w_nxt_state = S_FIN;
          w_nxt_err   = 1'b1;
        end else begin
          w_nxt_state = cmd_store ? S_STW : S_MEM;
          w_nxt_err   = 1'b0;
        end
      end
      S_STW: if (st_valid) w_nxt_state = S_MEM;
      S_MEM: if (mem_ready) begin
        if (!r_store) w_nxt_state = S_LDO;
        else if (w_last) w_nxt_state = S_FIN;
        else if (f_misal(w_nxt_addr[1:0], r_sew)) begin
          w_nxt_state = S_FIN;
          w_nxt_err   = 1'b1;
        end else w_nxt_state = S_STW;
      end
      S_LDO: if (ld_ready) begin
        if (w_last) w_nxt_state = S_FIN;
        else if (f_misal(w_nxt_addr[1:0], r_sew)) begin
          w_nxt_state = S_FIN;
          w_nxt_err   = 1'b1;
        end else w_nxt_state = S_MEM;
      end
      S_FIN:   w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    st_ready  = (r_state == S_STW);
    ld_valid  = (r_state == S_LDO);
    done      = (r_state == S_FIN);
    err       = (r_state == S_FIN) && r_err;
    ld_data   = r_ld_data;
    ld_idx    = r_i;
    mem_valid = r_mem_valid;
    mem_addr  = r_mem_addr;
    mem_wdata = r_wdata;
    mem_wstrb = r_wstrb;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err       <= 1'b0;
      r_store     <= 1'b0;
      r_sew       <= '0;
      r_addr      <= '0;
      r_stride    <= '0;
      r_vl        <= '0;
      r_i         <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_ld_data   <= '0;
    end else begin
      r_err <= w_nxt_err;
      unique case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_store     <= cmd_store;
          r_sew       <= cmd_sew;
          r_stride    <= cmd_stride;
          r_vl        <= w_vl_clamp;
          r_addr      <= cmd_base;
          r_i         <= '0;
          r_mem_valid <= (w_nxt_state == S_MEM);
          r_mem_addr  <= {cmd_base[31:2], 2'b00};
          r_wdata     <= '0;
          r_wstrb     <= '0;
        end
        S_STW: if (st_valid) begin
          r_mem_valid <= 1'b1;
          r_mem_addr  <= {r_addr[31:2], 2'b00};
          r_wdata     <= (st_data & f_mask(r_sew)) << {w_off, 3'b000};
          r_wstrb     <= f_smask(r_sew) << w_off;
        end
        S_MEM: if (mem_ready) begin
          r_mem_valid <= 1'b0;
          if (r_store) begin
            r_addr <= w_nxt_addr;
            r_i    <= r_i + VLW'(1);
          end else begin
            r_ld_data <= (mem_rdata >> {w_off, 3'b000}) & f_mask(r_sew);
          end
        end
        S_LDO: if (ld_ready) begin
          r_addr      <= w_nxt_addr;
          r_i         <= r_i + VLW'(1);
          r_mem_valid <= (w_nxt_state == S_MEM);
          r_mem_addr  <= {w_nxt_addr[31:2], 2'b00};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_stride_lsu.sv
// Scoreboard bench for vec_stride_lsu: a byte-level reference model queues the
// expected memory beats, load elements and done/err, checked as the DUT emits them.
module tb_vec_stride_lsu;
  localparam int unsigned MAX_VL = 32;
  localparam int unsigned VLW    = $clog2(MAX_VL + 1);

  logic           clk, resetn;
  logic           cmd_valid, cmd_ready, cmd_store;
  logic [31:0]    cmd_base, cmd_stride;
  logic [VLW-1:0] cmd_vl;
  logic [1:0]     cmd_sew;
  logic           ld_valid, ld_ready;
  logic [31:0]    ld_data;
  logic [VLW-1:0] ld_idx;
  logic           st_valid, st_ready;
  logic [31:0]    st_data;
  logic           mem_valid, mem_ready;
  logic [31:0]    mem_addr, mem_wdata, mem_rdata;
  logic [3:0]     mem_wstrb;
  logic           done, err;

  vec_stride_lsu #(.MAX_VL(MAX_VL)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_vl(cmd_vl), .cmd_sew(cmd_sew),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_idx(ld_idx),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_mv  = 0;

  logic [31:0] q_maddr[$], q_wdata[$], q_ld_data[$], q_ld_idx[$];
  logic [3:0]  q_wstrb[$];
  logic        q_err[$];
  logic        cur_store;
  logic [31:0] st_seed;
  logic [31:0] st_k;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Memory: word array, mem_ready one cycle after mem_valid, byte-strobed writes.
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      for (int w = 0; w < 256; w++) mem[w] <= 32'h0;
      mem[99]  <= 32'hA5A5_5A5A;
      mem[100] <= 32'h0403_0201;
      mem[101] <= 32'h0807_0605;
      mem[102] <= 32'h0C0B_0A09;
      mem[103] <= 32'h100F_0E0D;
    end else begin
      if (mem_valid && mem_ready)
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_ready <= mem_valid && !mem_ready;
    end
  end

  // Store element source: seed + number of elements already accepted.
  assign st_data = st_seed + st_k;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) st_k <= 32'h0;
    else if (cmd_valid && cmd_ready) st_k <= 32'h0;
    else if (st_valid && st_ready) st_k <= st_k + 32'h1;
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (mem_valid) begin
        n_mv++;
        if (q_maddr.size() == 0) chk("mem_unexpected", 32'(q_maddr.size()), 32'd1);
        else begin
          chk("mem_addr", mem_addr, q_maddr[0]);
          chk("mem_wstrb", 32'(mem_wstrb), 32'(q_wstrb[0]));
          if (cur_store) chk("mem_wdata", mem_wdata, q_wdata[0]);
          if (mem_ready) begin
            void'(q_maddr.pop_front());
            void'(q_wstrb.pop_front());
            if (cur_store) void'(q_wdata.pop_front());
          end
        end
      end
      if (ld_valid && ld_ready) begin
        if (q_ld_data.size() == 0) chk("ld_unexpected", 32'(q_ld_data.size()), 32'd1);
        else begin
          chk("ld_data", ld_data, q_ld_data.pop_front());
          chk("ld_idx", 32'(ld_idx), q_ld_idx.pop_front());
        end
      end
      if (done) begin
        if (q_err.size() == 0) chk("done_unexpected", 32'(q_err.size()), 32'd1);
        else chk("err", 32'(err), 32'(q_err.pop_front()));
      end
    end
  end

  task automatic prep(input bit st, input logic [31:0] base, input logic [31:0] stride,
                      input int vl, input logic [1:0] sew, input logic [31:0] seed);
    int n, nb;
    bit e;
    logic [31:0] a, x, d, wd;
    logic [3:0] sb;
    n = (vl > int'(MAX_VL)) ? int'(MAX_VL) : vl;
    e = 1'b0;
    cur_store = st;
    st_seed = seed;
    if (n != 0 && sew == 2'b11) e = 1'b1;
    else begin
      for (int i = 0; i < n; i++) begin
        a = base + stride * 32'(i);
        if ((sew == 2'd1 && a[0]) || (sew == 2'd2 && a[1:0] != 2'b00)) begin
          e = 1'b1;
          break;
        end
        nb = 1 << sew;
        q_maddr.push_back({a[31:2], 2'b00});
        if (st) begin
          d = seed + 32'(i);
          wd = 32'h0;
          sb = 4'h0;
          for (int b = 0; b < nb; b++) begin
            wd[8*(int'(a[1:0]) + b) +: 8] = d[8*b +: 8];
            sb[int'(a[1:0]) + b] = 1'b1;
          end
          q_wdata.push_back(wd);
          q_wstrb.push_back(sb);
        end else begin
          d = 32'h0;
          for (int b = 0; b < nb; b++) begin
            x = a + 32'(b);
            d[8*b +: 8] = mem[x[9:2]][8*int'(x[1:0]) +: 8];
          end
          q_ld_data.push_back(d);
          q_ld_idx.push_back(32'(i));
          q_wstrb.push_back(4'h0);
        end
      end
    end
    q_err.push_back(e);
  endtask

  task automatic issue(input bit st, input logic [31:0] base, input logic [31:0] stride,
                       input int vl, input logic [1:0] sew);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_store = st; cmd_base = base; cmd_stride = stride;
    cmd_vl = VLW'(vl); cmd_sew = sew;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input bit st, input logic [31:0] base,
                         input logic [31:0] stride, input int vl, input logic [1:0] sew,
                         input logic [31:0] seed, input int exp_lat, input bit hold,
                         input int exp_mv);
    int lat, mv0;
    bit got;
    logic [31:0] held;
    prep(st, base, stride, vl, sew, seed);
    if (hold) ld_ready = 1'b0;
    mv0 = n_mv;
    issue(st, base, stride, vl, sew);
    if (hold) begin
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (ld_valid) begin got = 1'b1; break; end
      end
      chk({tag, "_ldv_seen"}, 32'(got), 32'd1);
      held = q_ld_data.size() != 0 ? q_ld_data[0] : 32'hDEAD_BEEF;
      for (int k = 0; k < 5; k++) begin
        if (k != 0) @(negedge clk);
        chk({tag, "_hold_valid"}, 32'(ld_valid), 32'd1);
        chk({tag, "_hold_data"}, ld_data, held);
      end
      @(posedge clk);
      #1 ld_ready = 1'b1;
    end
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      lat++;
      if (done) begin got = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    if (exp_lat > 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (exp_mv >= 0) chk({tag, "_mem_cycles"}, 32'(n_mv - mv0), 32'(exp_mv));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_beats_left"}, 32'(q_maddr.size() + q_ld_data.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 1'b0; cmd_store = 1'b0; cmd_base = '0; cmd_stride = '0;
    cmd_vl = '0; cmd_sew = '0; ld_ready = 1'b1; st_valid = 1'b1;
    cur_store = 1'b0; st_seed = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #20;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_ld_valid", 32'(ld_valid), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    chk("rst_mem_out", mem_addr | mem_wdata | 32'(mem_wstrb), 32'd0);
    @(negedge clk) resetn = 1'b1;

    run_cmd("ld_s1_sew8",   1'b0, 32'd400, 32'd1, 12, 2'd0, 32'h0, 37, 1'b0, 24);
    run_cmd("ld_s4_sew8",   1'b0, 32'd400, 32'd4, 4,  2'd0, 32'h0, 13, 1'b0, 8);
    run_cmd("st_s1_sew8",   1'b1, 32'd600, 32'd1, 4,  2'd0, 32'hABCD_EF11, 13, 1'b0, 8);
    chk("word150", mem[150], 32'h1413_1211);
    run_cmd("ld_neg_sew16", 1'b0, 32'd402, 32'hFFFF_FFFE, 3, 2'd1, 32'h0, 10, 1'b0, 6);
    run_cmd("ld_misal16",   1'b0, 32'd401, 32'd2, 4,  2'd1, 32'h0, 1,  1'b0, 0);
    run_cmd("ld_vl0",       1'b0, 32'd400, 32'd4, 0,  2'd0, 32'h0, 1,  1'b0, 0);
    run_cmd("st_badsew",    1'b1, 32'd600, 32'd4, 3,  2'd3, 32'h0, 1,  1'b0, 0);
    run_cmd("ld_misal_mid", 1'b0, 32'd400, 32'd2, 3,  2'd2, 32'h0, 4,  1'b0, 2);
    run_cmd("ld_clamp_s0",  1'b0, 32'd404, 32'd0, 40, 2'd2, 32'h0, 97, 1'b0, 64);
    run_cmd("st_sew16",     1'b1, 32'd642, 32'd4, 2,  2'd1, 32'h5566_7788, 7, 1'b0, 4);
    run_cmd("ld_hold",      1'b0, 32'd400, 32'd4, 3,  2'd0, 32'h0, -1, 1'b1, 6);

    prep(1'b1, 32'd640, 32'd4, 8, 2'd2, 32'h1234_0000);
    issue(1'b1, 32'd640, 32'd4, 8, 2'd2);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_valid) break;
    end
    #2 resetn = 1'b0;
    #1;
    chk("arst_mem_valid", 32'(mem_valid), 32'd0);
    chk("arst_st_ready", 32'(st_ready), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    q_maddr.delete(); q_wdata.delete(); q_wstrb.delete();
    q_ld_data.delete(); q_ld_idx.delete(); q_err.delete();
    @(negedge clk);
    @(negedge clk) resetn = 1'b1;
    @(negedge clk);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    run_cmd("ld_after_rst", 1'b0, 32'd400, 32'd4, 4, 2'd0, 32'h0, 13, 1'b0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
